// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcode constants, widths and
// the FSM state encodings.
package ctrl_pkg;

  localparam int OPW    = 5;  // opcode width, IR[31:27]
  localparam int STEP_W = 4;  // state register width

  localparam logic [OPW-1:0] OP_ADDI = 5'b10001;
  localparam logic [OPW-1:0] OP_ANDI = 5'b10010;
  localparam logic [OPW-1:0] OP_ORI  = 5'b10011;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [STEP_W-1:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T1W  = 4'd3,
    T2   = 4'd4,
    T3   = 4'd5,
    T4   = 4'd6,
    T5   = 4'd7,
    HALT = 4'd8
  } step_e;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: maps IR[31:27] to exactly one of
// alu-immediate / nop / halt / illegal.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output logic           is_alu_imm_o,
  output logic           is_nop_o,
  output logic           is_halt_o,
  output logic           is_illegal_o
);

  // Classify the opcode; anything not recognised is illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    is_alu_imm_o = 1'b0;
    is_nop_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_ADDI, OP_ANDI, OP_ORI: is_alu_imm_o = 1'b1;
      OP_NOP:                   is_nop_o     = 1'b1;
      OP_HALT:                  is_halt_o    = 1'b1;
      default:                  is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit for the Bus datapath: instruction fetch with
// memory wait states, then execute for addi/andi/ori, plus nop and halt.
// Optional build macro CTRL_INSTR_COUNT_EN adds the instr_count output, a
// wrapping count of completed ALU and nop instructions.
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           run_in,
  input  logic           mem_rdy,
  input  logic [31:0]    IR,
  output logic           PCout,
  output logic           MARins,
  output logic           incPC,
  output logic           Zins,
  output logic           ZLOout,
  output logic           PCins,
  output logic           MDRRead,
  output logic           MDRins,
  output logic           MDRout,
  output logic           IRins,
  output logic           Gra,
  output logic           Grb,
  output logic           Rins,
  output logic           Routs,
  output logic           BAOut,
  output logic           Cout,
  output logic           Yins,
  output logic [OPW-1:0] ALUop,
  output logic           run,
  output logic           illegal
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [31:0]    instr_count
`endif
);

  step_e          state_q;
  logic           illegal_q;
  logic [OPW-1:0] opcode;
  logic           is_alu_imm;
  logic           is_nop;
  logic           is_halt;
  logic           is_illegal;

  // Register/constant fields are decoded by the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  assign opcode = IR[31:27];

  opcode_decoder u_opcode_decoder (
    .opcode_i     (opcode),
    .is_alu_imm_o (is_alu_imm),
    .is_nop_o     (is_nop),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  // Sequencer state and sticky illegal flag; clr overrides every transition.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (clr) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (run_in) state_q <= T0;
        T0:      state_q <= T1;
        // T1W repeats the read without reloading PC until memory answers.
        T1, T1W: state_q <= mem_rdy ? T2 : T1W;
        T2:      state_q <= T3;
        T3: begin
          if (is_alu_imm)   state_q <= T4;
          else if (is_nop)  state_q <= T0;
          else if (is_halt) state_q <= HALT;
          else begin
            illegal_q <= 1'b1;
            state_q   <= HALT;
          end
        end
        T4:      state_q <= T5;
        T5:      state_q <= run_in ? T0 : IDLE;
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore output decode of the present state.
  always_comb begin
    PCout   = 1'b0;
    MARins  = 1'b0;
    incPC   = 1'b0;
    Zins    = 1'b0;
    ZLOout  = 1'b0;
    PCins   = 1'b0;
    MDRRead = 1'b0;
    MDRins  = 1'b0;
    MDRout  = 1'b0;
    IRins   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Rins    = 1'b0;
    Routs   = 1'b0;
    BAOut   = 1'b0;
    Cout    = 1'b0;
    Yins    = 1'b0;
    ALUop   = '0;
    case (state_q)
      T0: begin
        PCout  = 1'b1;
        MARins = 1'b1;
        incPC  = 1'b1;
        Zins   = 1'b1;
      end
      T1: begin
        ZLOout  = 1'b1;
        PCins   = 1'b1;
        MDRRead = 1'b1;
        MDRins  = 1'b1;
      end
      T1W: begin
        MDRRead = 1'b1;
        MDRins  = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRins  = 1'b1;
      end
      T3: begin
        Grb   = 1'b1;
        Routs = 1'b1;
        Yins  = 1'b1;
      end
      T4: begin
        Cout  = 1'b1;
        Zins  = 1'b1;
        ALUop = opcode;
      end
      T5: begin
        ZLOout = 1'b1;
        Gra    = 1'b1;
        Rins   = 1'b1;
      end
      default: ;
    endcase
  end

  assign run     = (state_q != HALT);
  assign illegal = illegal_q;

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] instr_count_q;

  // Count instructions that complete normally: leaving T5, or nop leaving T3.
  always_ff @(posedge clk) begin
    if (clr) begin
      instr_count_q <= '0;
    end else if ((state_q == T5) || ((state_q == T3) && is_nop)) begin
      instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table-driven cycle vectors plus
// hand-written sequences, with expected outputs queued on drive and compared
// when the DUT has stepped.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run_in = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] IR = '0;
  logic PCout, MARins, incPC, Zins, ZLOout, PCins, MDRRead, MDRins, MDRout;
  logic IRins, Gra, Grb, Rins, Routs, BAOut, Cout, Yins;
  logic [4:0]  ALUop;
  logic        run, illegal;
`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  control_sequencer dut (
    .clk(clk), .clr(clr), .run_in(run_in), .mem_rdy(mem_rdy), .IR(IR),
    .PCout(PCout), .MARins(MARins), .incPC(incPC), .Zins(Zins),
    .ZLOout(ZLOout), .PCins(PCins), .MDRRead(MDRRead), .MDRins(MDRins),
    .MDRout(MDRout), .IRins(IRins), .Gra(Gra), .Grb(Grb), .Rins(Rins),
    .Routs(Routs), .BAOut(BAOut), .Cout(Cout), .Yins(Yins),
    .ALUop(ALUop), .run(run), .illegal(illegal)
`ifdef CTRL_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Control enables packed as one word, MSB first.
  logic [16:0] act_ctl;
  assign act_ctl = {PCout, MARins, incPC, Zins, ZLOout, PCins, MDRRead, MDRins,
                    MDRout, IRins, Gra, Grb, Rins, Routs, BAOut, Cout, Yins};

  localparam logic [16:0] B_PCOUT   = 17'h10000;
  localparam logic [16:0] B_MARINS  = 17'h08000;
  localparam logic [16:0] B_INCPC   = 17'h04000;
  localparam logic [16:0] B_ZINS    = 17'h02000;
  localparam logic [16:0] B_ZLOOUT  = 17'h01000;
  localparam logic [16:0] B_PCINS   = 17'h00800;
  localparam logic [16:0] B_MDRREAD = 17'h00400;
  localparam logic [16:0] B_MDRINS  = 17'h00200;
  localparam logic [16:0] B_MDROUT  = 17'h00100;
  localparam logic [16:0] B_IRINS   = 17'h00080;
  localparam logic [16:0] B_GRA     = 17'h00040;
  localparam logic [16:0] B_GRB     = 17'h00020;
  localparam logic [16:0] B_RINS    = 17'h00010;
  localparam logic [16:0] B_ROUTS   = 17'h00008;
  localparam logic [16:0] B_COUT    = 17'h00002;
  localparam logic [16:0] B_YINS    = 17'h00001;

  localparam logic [16:0] E_NONE = 17'h0;
  localparam logic [16:0] E_T0   = B_PCOUT | B_MARINS | B_INCPC | B_ZINS;
  localparam logic [16:0] E_T1   = B_ZLOOUT | B_PCINS | B_MDRREAD | B_MDRINS;
  localparam logic [16:0] E_T1W  = B_MDRREAD | B_MDRINS;
  localparam logic [16:0] E_T2   = B_MDROUT | B_IRINS;
  localparam logic [16:0] E_T3   = B_GRB | B_ROUTS | B_YINS;
  localparam logic [16:0] E_T4   = B_COUT | B_ZINS;
  localparam logic [16:0] E_T5   = B_ZLOOUT | B_GRA | B_RINS;

  localparam logic [31:0] I_ADDI = 32'h88000136;
  localparam logic [31:0] I_ANDI = 32'h900001FF;
  localparam logic [31:0] I_ORI  = 32'h98000155;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_BAD  = 32'h00000000;
  localparam logic [31:0] I_JUNK = 32'h12345678;

  typedef struct {
    logic        clr;
    logic        run_in;
    logic        mem_rdy;
    logic [31:0] ir;
    logic [16:0] ctl;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
    string       tag;
  } vec_t;

  typedef struct {
    logic [16:0] ctl;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
    string       tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic c, input logic r, input logic m,
                              input logic [31:0] ir, input logic [16:0] ctl,
                              input logic [4:0] alu, input logic rn,
                              input logic il, input string tag);
    vec_t v;
    v.clr = c; v.run_in = r; v.mem_rdy = m; v.ir = ir;
    v.ctl = ctl; v.alu = alu; v.run = rn; v.ill = il; v.tag = tag;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs, queue its expectation, let the DUT step,
  // then pop and compare on the falling edge.
  task automatic step(input logic c, input logic r, input logic m,
                      input logic [31:0] ir, input logic [16:0] ctl,
                      input logic [4:0] alu, input logic rn, input logic il,
                      input string tag);
    exp_t e;
    clr = c; run_in = r; mem_rdy = m; IR = ir;
    e.ctl = ctl; e.alu = alu; e.run = rn; e.ill = il; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".ctl"},     {15'd0, act_ctl}, {15'd0, e.ctl});
    check({e.tag, ".aluop"},   {27'd0, ALUop},   {27'd0, e.alu});
    check({e.tag, ".run"},     {31'd0, run},     {31'd0, e.run});
    check({e.tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, addi, back-to-back andi/ori, a 3-cycle memory wait, then halt.
    add(1,0,0,I_ADDI, E_NONE,5'b0,    1,0,"reset");
    add(0,1,1,I_ADDI, E_T0,  5'b0,    1,0,"addi_t0");
    add(0,1,1,I_ADDI, E_T1,  5'b0,    1,0,"addi_t1");
    add(0,1,1,I_ADDI, E_T2,  5'b0,    1,0,"addi_t2");
    add(0,1,1,I_ADDI, E_T3,  5'b0,    1,0,"addi_t3");
    add(0,1,1,I_ADDI, E_T4,  5'b10001,1,0,"addi_t4");
    add(0,1,1,I_ADDI, E_T5,  5'b0,    1,0,"addi_t5");
    add(0,1,1,I_ADDI, E_T0,  5'b0,    1,0,"andi_t0");
    add(0,1,1,I_ADDI, E_T1,  5'b0,    1,0,"andi_t1");
    add(0,1,1,I_ANDI, E_T2,  5'b0,    1,0,"andi_t2");
    add(0,1,1,I_ANDI, E_T3,  5'b0,    1,0,"andi_t3");
    add(0,1,1,I_ANDI, E_T4,  5'b10010,1,0,"andi_t4");
    add(0,1,1,I_ANDI, E_T5,  5'b0,    1,0,"andi_t5");
    add(0,1,1,I_ANDI, E_T0,  5'b0,    1,0,"ori_t0");
    add(0,1,1,I_ANDI, E_T1,  5'b0,    1,0,"ori_t1");
    add(0,1,1,I_ORI,  E_T2,  5'b0,    1,0,"ori_t2");
    add(0,1,1,I_ORI,  E_T3,  5'b0,    1,0,"ori_t3");
    add(0,1,1,I_ORI,  E_T4,  5'b10011,1,0,"ori_t4");
    add(0,1,1,I_ORI,  E_T5,  5'b0,    1,0,"ori_t5");
    add(0,1,0,I_ORI,  E_T0,  5'b0,    1,0,"wait_t0");
    add(0,1,0,I_ORI,  E_T1,  5'b0,    1,0,"wait_t1");
    add(0,1,0,I_ORI,  E_T1W, 5'b0,    1,0,"wait_t1w_a");
    add(0,1,0,I_ORI,  E_T1W, 5'b0,    1,0,"wait_t1w_b");
    add(0,1,0,I_ORI,  E_T1W, 5'b0,    1,0,"wait_t1w_c");
    add(0,1,1,I_HALT, E_T2,  5'b0,    1,0,"wait_t2");
    add(0,1,0,I_HALT, E_T3,  5'b0,    1,0,"halt_t3");
    add(0,1,1,I_HALT, E_NONE,5'b0,    0,0,"halt");
    foreach (tbl[i])
      step(tbl[i].clr, tbl[i].run_in, tbl[i].mem_rdy, tbl[i].ir,
           tbl[i].ctl, tbl[i].alu, tbl[i].run, tbl[i].ill, tbl[i].tag);

    // HALT must stay frozen whatever the other inputs do.
    for (int i = 0; i < 20; i++)
      step(0, 1'($urandom), 1'($urandom), $urandom, E_NONE, 5'b0, 0, 0, "halt_frozen");

    // Undecodable opcode: sticky illegal, halted.
    step(1,0,0,I_BAD, E_NONE,5'b0,1,0,"ill_reset");
    step(0,1,1,I_BAD, E_T0,  5'b0,1,0,"ill_t0");
    step(0,1,1,I_BAD, E_T1,  5'b0,1,0,"ill_t1");
    step(0,1,1,I_BAD, E_T2,  5'b0,1,0,"ill_t2");
    step(0,1,1,I_BAD, E_T3,  5'b0,1,0,"ill_t3");
    step(0,1,1,I_BAD, E_NONE,5'b0,0,1,"ill_halt");
    step(0,1,1,I_ADDI,E_NONE,5'b0,0,1,"ill_sticky");

    // Reset in the middle of execute, then refetch.
    step(1,0,0,I_ADDI,E_NONE,5'b0,    1,0,"mid_reset");
    step(0,1,1,I_ADDI,E_T0,  5'b0,    1,0,"mid_t0");
    step(0,1,1,I_ADDI,E_T1,  5'b0,    1,0,"mid_t1");
    step(0,1,1,I_ADDI,E_T2,  5'b0,    1,0,"mid_t2");
    step(0,1,1,I_ADDI,E_T3,  5'b0,    1,0,"mid_t3");
    step(0,1,1,I_ADDI,E_T4,  5'b10001,1,0,"mid_t4");
    step(1,1,1,I_ADDI,E_NONE,5'b0,    1,0,"clr_in_t4");
    step(0,1,1,I_ADDI,E_T0,  5'b0,    1,0,"refetch_t0");

    // run_in drops mid-instruction; IR junk outside T3/T4 is ignored.
    step(0,0,1,I_JUNK,E_T1,  5'b0,    1,0,"drop_t1");
    step(0,0,1,I_JUNK,E_T2,  5'b0,    1,0,"drop_t2");
    step(0,0,1,I_JUNK,E_T3,  5'b0,    1,0,"drop_t3");
    step(0,0,1,I_ADDI,E_T4,  5'b10001,1,0,"drop_t4");
    step(0,0,1,I_JUNK,E_T5,  5'b0,    1,0,"drop_t5");
    step(0,0,1,I_JUNK,E_NONE,5'b0,    1,0,"drop_idle");
    step(0,0,1,I_JUNK,E_NONE,5'b0,    1,0,"drop_idle_hold");

    // nop returns straight to T0.
    step(0,1,1,I_JUNK,E_T0,  5'b0,    1,0,"nop_t0");
    step(0,1,1,I_JUNK,E_T1,  5'b0,    1,0,"nop_t1");
    step(0,1,1,I_JUNK,E_T2,  5'b0,    1,0,"nop_t2");
    step(0,1,1,I_NOP, E_T3,  5'b0,    1,0,"nop_t3");
    step(0,1,1,I_NOP, E_T0,  5'b0,    1,0,"nop_next_t0");

`ifdef CTRL_INSTR_COUNT_EN
    // addi, nop, ori, halt: three counted instructions.
    step(1,0,0,I_ADDI,E_NONE,5'b0,1,0,"cnt_reset");
    check("cnt_after_reset", instr_count, 32'd0);
    step(0,1,1,I_ADDI,E_T0,  5'b0,    1,0,"cnt_addi_t0");
    step(0,1,1,I_ADDI,E_T1,  5'b0,    1,0,"cnt_addi_t1");
    step(0,1,1,I_ADDI,E_T2,  5'b0,    1,0,"cnt_addi_t2");
    step(0,1,1,I_ADDI,E_T3,  5'b0,    1,0,"cnt_addi_t3");
    step(0,1,1,I_ADDI,E_T4,  5'b10001,1,0,"cnt_addi_t4");
    step(0,1,1,I_ADDI,E_T5,  5'b0,    1,0,"cnt_addi_t5");
    check("cnt_before_addi_done", instr_count, 32'd0);
    step(0,1,1,I_NOP, E_T0,  5'b0,    1,0,"cnt_nop_t0");
    check("cnt_after_addi", instr_count, 32'd1);
    step(0,1,1,I_NOP, E_T1,  5'b0,    1,0,"cnt_nop_t1");
    step(0,1,1,I_NOP, E_T2,  5'b0,    1,0,"cnt_nop_t2");
    step(0,1,1,I_NOP, E_T3,  5'b0,    1,0,"cnt_nop_t3");
    step(0,1,1,I_NOP, E_T0,  5'b0,    1,0,"cnt_ori_t0");
    check("cnt_after_nop", instr_count, 32'd2);
    step(0,1,1,I_ORI, E_T1,  5'b0,    1,0,"cnt_ori_t1");
    step(0,1,1,I_ORI, E_T2,  5'b0,    1,0,"cnt_ori_t2");
    step(0,1,1,I_ORI, E_T3,  5'b0,    1,0,"cnt_ori_t3");
    step(0,1,1,I_ORI, E_T4,  5'b10011,1,0,"cnt_ori_t4");
    step(0,1,1,I_ORI, E_T5,  5'b0,    1,0,"cnt_ori_t5");
    step(0,1,1,I_HALT,E_T0,  5'b0,    1,0,"cnt_halt_t0");
    step(0,1,1,I_HALT,E_T1,  5'b0,    1,0,"cnt_halt_t1");
    step(0,1,1,I_HALT,E_T2,  5'b0,    1,0,"cnt_halt_t2");
    step(0,1,1,I_HALT,E_T3,  5'b0,    1,0,"cnt_halt_t3");
    step(0,1,1,I_HALT,E_NONE,5'b0,    0,0,"cnt_halt");
    for (int i = 0; i < 5; i++) begin
      step(0,1,1,I_NOP,E_NONE,5'b0,0,0,"cnt_halt_hold");
      check("cnt_final", instr_count, 32'd3);
    end
`endif

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
